mod_updown_counter: RTL and testbench

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_updown_counter_pkg.sv | 17 +
 rtl/mod_updown_counter_next_count.sv | 56 +++++
 rtl/mod_updown_counter.sv | 87 ++++++++
 tb/tb_mod_updown_counter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_updown_counter_pkg.sv
// rtl/mod_updown_counter_pkg.sv - shared constants for the up/down counter
//
// Purpose: end-of-range mode constants and default geometry shared by the
// counter top level and its next-count helper.
// Ports: none (package).

package mod_updown_counter_pkg;

  // End-of-range behaviour selected by the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Default counter geometry
  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 16;

endpackage : mod_updown_counter_pkg

// File: rtl/mod_updown_counter_next_count.sv
// rtl/mod_updown_counter_next_count.sv - combinational next-count and wrap flag
//
// Purpose: given the current count and direction, produce the value the counter
// takes on an enabled edge and whether that step is a wrap event.
// Ports:
//   i_q      in  WIDTH  current count
//   i_up_dn  in  1      direction, 1 = up, 0 = down
//   o_next   out WIDTH  next count for an enabled edge
//   o_wrap   out 1      high when the step crosses a range end in wrap mode

module mod_next_count
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MODULUS  = DEFAULT_MODULUS,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up_dn,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);
  localparam logic             C_SAT = (SATURATE == MODE_SAT);

  always_comb begin
    o_next = i_q;
    o_wrap = 1'b0;
    if (i_up_dn) begin
      // >= rather than == so any out-of-range value still lands in range
      if (i_q >= C_MAX) begin
        if (C_SAT) begin
          o_next = C_MAX;
        end else begin
          o_next = '0;
          o_wrap = 1'b1;
        end
      end else begin
        o_next = i_q + WIDTH'(1);
      end
    end else begin
      if (i_q == '0) begin
        if (!C_SAT) begin
          o_next = C_MAX;
          o_wrap = 1'b1;
        end
      end else if (i_q > C_MAX) begin
        o_next = C_MAX;
      end else begin
        o_next = i_q - WIDTH'(1);
      end
    end
  end

endmodule : mod_next_count

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo up/down counter with load, wrap pulse and terminal count
//
// Purpose: counts 0..MODULUS-1 up or down, wrapping or saturating at the range
// ends, with a clamped synchronous parallel load. Edge priority is
// rst > load > en > hold.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      asynchronous active-high reset
//   en        in  1      count enable
//   up_dn     in  1      direction, 1 = up, 0 = down
//   load      in  1      synchronous parallel load strobe
//   load_val  in  WIDTH  load value, clamped to MODULUS-1
//   Q         out WIDTH  registered count
//   tc        out 1      terminal count for the current direction (combinational)
//   wrapped   out 1      registered one-cycle pulse per wrap event

module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MODULUS  = DEFAULT_MODULUS,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrapped
);

  if (WIDTH < 1) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be >= 1");
  end
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("mod_updown_counter: SATURATE must be MODE_WRAP or MODE_SAT");
  end

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrapped;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic [WIDTH-1:0] w_load_q;

  mod_next_count #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next_count (
    .i_q     (r_q),
    .i_up_dn (up_dn),
    .o_next  (w_next),
    .o_wrap  (w_wrap)
  );

  // Out-of-range load values clamp to the top of the range
  assign w_load_q = (load_val > C_MAX) ? C_MAX : load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_wrapped <= 1'b0;
    end else if (load) begin
      r_q       <= w_load_q;
      r_wrapped <= 1'b0;
    end else if (en) begin
      r_q       <= w_next;
      r_wrapped <= w_wrap;
    end else begin
      r_wrapped <= 1'b0;
    end
  end

  assign Q       = r_q;
  assign wrapped = r_wrapped;
  // Terminal count follows the live direction, independent of en and mode
  assign tc      = up_dn ? (r_q == C_MAX) : (r_q == '0);

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - directed self-checking bench for mod_updown_counter

module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] q10, qsat;
  logic       tc10, tcsat, wr10, wrsat;
  logic [0:0] q2;
  logic       tc2, wr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Q(q10), .tc(tc10), .wrapped(wr10)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dutsat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Q(qsat), .tc(tcsat), .wrapped(wrsat)
  );

  mod_updown_counter #(.WIDTH(1), .MODULUS(2), .SATURATE(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[0:0]), .Q(q2), .tc(tc2), .wrapped(wr2)
  );

  // Advance one rising edge, returning at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    up_dn = 1'b0;
    #1;
    checks++; if (q10 !== 4'd0) begin errors++; $display("FAIL reset_q got %0d exp 0", q10); end
    checks++; if (wr10 !== 1'b0) begin errors++; $display("FAIL reset_wrapped got %0b exp 0", wr10); end
    checks++; if (tc10 !== 1'b1) begin errors++; $display("FAIL reset_tc_down got %0b exp 1", tc10); end
    up_dn = 1'b1;
    #1;
    checks++; if (tc10 !== 1'b0) begin errors++; $display("FAIL reset_tc_up got %0b exp 0", tc10); end
    @(negedge clk);
  endtask

  task automatic test_count_up();
    logic [3:0] eq;
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      eq = 4'(k % 10);
      checks++; if (q10 !== eq) begin errors++; $display("FAIL up_q k=%0d got %0d exp %0d", k, q10, eq); end
      checks++; if (wr10 !== (k == 10)) begin errors++; $display("FAIL up_wrapped k=%0d got %0b exp %0b", k, wr10, (k == 10)); end
      checks++; if (tc10 !== (eq == 4'd9)) begin errors++; $display("FAIL up_tc k=%0d got %0b exp %0b", k, tc10, (eq == 4'd9)); end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] eq;
    do_reset();
    en = 1'b1; up_dn = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      eq = 4'((10 - (k % 10)) % 10);
      checks++; if (q10 !== eq) begin errors++; $display("FAIL down_q k=%0d got %0d exp %0d", k, q10, eq); end
      checks++; if (wr10 !== (k == 1 || k == 11)) begin errors++; $display("FAIL down_wrapped k=%0d got %0b exp %0b", k, wr10, (k == 1 || k == 11)); end
      checks++; if (tc10 !== (eq == 4'd0)) begin errors++; $display("FAIL down_tc k=%0d got %0b exp %0b", k, tc10, (eq == 4'd0)); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    load = 1'b1; load_val = 4'd9; up_dn = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (qsat !== 4'd9) begin errors++; $display("FAIL sat_hold_q k=%0d got %0d exp 9", k, qsat); end
      checks++; if (wrsat !== 1'b0) begin errors++; $display("FAIL sat_hold_wrapped k=%0d got %0b exp 0", k, wrsat); end
      checks++; if (tcsat !== 1'b1) begin errors++; $display("FAIL sat_tc k=%0d got %0b exp 1", k, tcsat); end
    end
    up_dn = 1'b0;
    #1;
    checks++; if (tcsat !== 1'b0) begin errors++; $display("FAIL sat_tc_dirchg got %0b exp 0", tcsat); end
    step();
    checks++; if (qsat !== 4'd8) begin errors++; $display("FAIL sat_down_q got %0d exp 8", qsat); end
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    step();
    checks++; if (qsat !== 4'd0) begin errors++; $display("FAIL sat_floor_q got %0d exp 0", qsat); end
    checks++; if (wrsat !== 1'b0) begin errors++; $display("FAIL sat_floor_wrapped got %0b exp 0", wrsat); end
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; load_val = 4'd12;
    step();
    checks++; if (q10 !== 4'd9) begin errors++; $display("FAIL load_clamp12 got %0d exp 9", q10); end
    load_val = 4'd15;
    step();
    checks++; if (q10 !== 4'd9) begin errors++; $display("FAIL load_clamp15 got %0d exp 9", q10); end
    en = 1'b1; up_dn = 1'b1; load_val = 4'd9;
    step();
    checks++; if (q10 !== 4'd9) begin errors++; $display("FAIL load_over_wrap_q got %0d exp 9", q10); end
    checks++; if (wr10 !== 1'b0) begin errors++; $display("FAIL load_over_wrap_wrapped got %0b exp 0", wr10); end
    load_val = 4'd3;
    step();
    checks++; if (q10 !== 4'd3) begin errors++; $display("FAIL load_wins_up got %0d exp 3", q10); end
    up_dn = 1'b0; load_val = 4'd0;
    step();
    checks++; if (q10 !== 4'd0) begin errors++; $display("FAIL load_wins_down got %0d exp 0", q10); end
    load = 1'b0;
    step();
    checks++; if (q10 !== 4'd9 || wr10 !== 1'b1) begin errors++; $display("FAIL after_load_wrap got q=%0d w=%0b exp q=9 w=1", q10, wr10); end
  endtask

  task automatic test_hold();
    en = 1'b0;
    step();
    checks++; if (q10 !== 4'd9) begin errors++; $display("FAIL hold_q got %0d exp 9", q10); end
    checks++; if (wr10 !== 1'b0) begin errors++; $display("FAIL hold_wrapped got %0b exp 0", wr10); end
    step();
    checks++; if (q10 !== 4'd9) begin errors++; $display("FAIL hold_q2 got %0d exp 9", q10); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load = 1'b1; load_val = 4'd5;
    step();
    load = 1'b0; en = 1'b1;
    up_dn = 1'b1; step();
    checks++; if (q10 !== 4'd6) begin errors++; $display("FAIL dir_up got %0d exp 6", q10); end
    up_dn = 1'b0; step();
    checks++; if (q10 !== 4'd5) begin errors++; $display("FAIL dir_down got %0d exp 5", q10); end
    step();
    checks++; if (q10 !== 4'd4) begin errors++; $display("FAIL dir_down2 got %0d exp 4", q10); end
    up_dn = 1'b1; step();
    checks++; if (q10 !== 4'd5) begin errors++; $display("FAIL dir_up2 got %0d exp 5", q10); end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks++; if (q10 !== 4'd5) begin errors++; $display("FAIL pre_rst_q got %0d exp 5", q10); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (q10 !== 4'd0) begin errors++; $display("FAIL async_rst_q got %0d exp 0", q10); end
    checks++; if (wr10 !== 1'b0) begin errors++; $display("FAIL async_rst_wrapped got %0b exp 0", wr10); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (q10 !== 4'd1) begin errors++; $display("FAIL rst_release_q got %0d exp 1", q10); end
    // Reset arriving while a wrap pulse is high must clear it immediately
    for (int k = 0; k < 9; k++) step();
    checks++; if (wr10 !== 1'b1) begin errors++; $display("FAIL pre_rst_wrapped got %0b exp 1", wr10); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wr10 !== 1'b0) begin errors++; $display("FAIL async_rst_clr_wrapped got %0b exp 0", wr10); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mod2();
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (q2 !== 1'(k % 2)) begin errors++; $display("FAIL mod2_q k=%0d got %0d exp %0d", k, q2, k % 2); end
      checks++; if (wr2 !== (k % 2 == 0)) begin errors++; $display("FAIL mod2_wrapped k=%0d got %0b exp %0b", k, wr2, (k % 2 == 0)); end
      checks++; if (tc2 !== (k % 2 == 1)) begin errors++; $display("FAIL mod2_tc k=%0d got %0b exp %0b", k, tc2, (k % 2 == 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_mod2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mod_updown_counter
